// File: rtl/tri_sched.sv
// Round-robin scheduler sharing one triangle rasterizer among N_REQ requesters.
// Serializes the granted triangle onto the engine and forwards its pixel stream.
module tri_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned TMO   = 80
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [9*N_REQ-1:0]   req_xv,
    input  logic [9*N_REQ-1:0]   req_yv,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic                 tri_nt,
    output logic [2:0]           tri_xi,
    output logic [2:0]           tri_yi,
    input  logic                 tri_busy,
    input  logic                 tri_po,
    input  logic [2:0]           tri_xo,
    input  logic [2:0]           tri_yo,
    output logic                 px_valid,
    output logic [2:0]           px_x,
    output logic [2:0]           px_y,
    output logic [ID_W-1:0]      px_id
);

    localparam int unsigned IDX_W = ID_W + 1;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND0,
        ST_SEND1,
        ST_SEND2,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] v2;
        logic [2:0] v1;
        logic [2:0] v0;
    } tri_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    rr_ptr, rr_d;
    logic [ID_W-1:0]    id_d;
    logic [2:0]         vx1_q, vx2_q, vy1_q, vy2_q;
    logic [2:0]         vx1_d, vx2_d, vy1_d, vy2_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [N_REQ-1:0]   ack_d, done_d;
    logic               err_d, nt_d, pxv_d;
    logic [2:0]         xi_d, yi_d, pxx_d, pxy_d;

    logic [IDX_W-1:0]   rr_sum [N_REQ];
    logic [ID_W-1:0]    rr_idx [N_REQ];
    logic               found;
    logic [ID_W-1:0]    winner;
    tri_t               xsel, ysel;

    // Search order: rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum[k] = IDX_W'(rr_ptr) + IDX_W'(k);
            rr_idx[k] = (rr_sum[k] >= IDX_W'(N_REQ)) ? ID_W'(rr_sum[k] - IDX_W'(N_REQ))
                                                      : ID_W'(rr_sum[k]);
        end
    end

    // First pending request in search order wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[rr_idx[k]]) begin
                found  = 1'b1;
                winner = rr_idx[k];
            end
        end
    end

    always_comb begin
        xsel = '0;
        ysel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                xsel = req_xv[9*k +: 9];
                ysel = req_yv[9*k +: 9];
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        id_d    = px_id;
        vx1_d   = vx1_q;
        vx2_d   = vx2_q;
        vy1_d   = vy1_q;
        vy2_d   = vy2_q;
        cnt_d   = cnt;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        nt_d    = 1'b0;
        xi_d    = '0;
        yi_d    = '0;
        pxv_d   = 1'b0;
        pxx_d   = '0;
        pxy_d   = '0;

        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_SEND0;
                    id_d    = winner;
                    vx1_d   = xsel.v1;
                    vx2_d   = xsel.v2;
                    vy1_d   = ysel.v1;
                    vy2_d   = ysel.v2;
                    ack_d   = N_REQ'(1) << winner;
                    rr_d    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
                    nt_d    = 1'b1;
                    xi_d    = xsel.v0;
                    yi_d    = ysel.v0;
                end
            end
            ST_SEND0: begin
                state_d = ST_SEND1;
                xi_d    = vx1_q;
                yi_d    = vy1_q;
            end
            ST_SEND1: begin
                state_d = ST_SEND2;
                xi_d    = vx2_q;
                yi_d    = vy2_q;
            end
            ST_SEND2: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                cnt_d = cnt + CNT_W'(1);
                if ((cnt >= CNT_W'(2)) && !tri_busy) begin
                    state_d = ST_DONE;
                    done_d  = N_REQ'(1) << px_id;
                end else if (cnt == CNT_W'(TMO - 1)) begin
                    state_d = ST_DONE;
                    done_d  = N_REQ'(1) << px_id;
                    err_d   = 1'b1;
                end else begin
                    // tri_po is only trusted while the engine reports busy
                    pxv_d = tri_po & tri_busy;
                    if (pxv_d) begin
                        pxx_d = tri_xo;
                        pxy_d = tri_yo;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, job context and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            px_id    <= '0;
            vx1_q    <= '0;
            vx2_q    <= '0;
            vy1_q    <= '0;
            vy2_q    <= '0;
            cnt      <= '0;
            ack      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tri_nt   <= 1'b0;
            tri_xi   <= '0;
            tri_yi   <= '0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_d;
            px_id    <= id_d;
            vx1_q    <= vx1_d;
            vx2_q    <= vx2_d;
            vy1_q    <= vy1_d;
            vy2_q    <= vy2_d;
            cnt      <= cnt_d;
            ack      <= ack_d;
            done     <= done_d;
            err      <= err_d;
            tri_nt   <= nt_d;
            tri_xi   <= xi_d;
            tri_yi   <= yi_d;
            px_valid <= pxv_d;
            px_x     <= pxx_d;
            px_y     <= pxy_d;
        end
    end

endmodule

// File: tb/tb_tri_sched.sv
// Directed bench for tri_sched with a behavioral engine that replays the
// three latched vertices as pixels; supports a hang mode for the watchdog.
module tb_tri_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [35:0] req_xv, req_yv;
    logic [3:0]  ack, done;
    logic        err, tri_nt;
    logic [2:0]  tri_xi, tri_yi;
    logic        tri_busy, tri_po;
    logic [2:0]  tri_xo, tri_yo;
    logic        px_valid;
    logic [2:0]  px_x, px_y;
    logic [1:0]  px_id;
    logic        eng_hang;

    int n_checks = 0;
    int n_errors = 0;

    tri_sched #(.N_REQ(4), .ID_W(2), .TMO(80)) dut (
        .clk(clk), .reset(reset), .req(req), .req_xv(req_xv), .req_yv(req_yv),
        .ack(ack), .done(done), .err(err), .tri_nt(tri_nt),
        .tri_xi(tri_xi), .tri_yi(tri_yi), .tri_busy(tri_busy), .tri_po(tri_po),
        .tri_xo(tri_xo), .tri_yo(tri_yo), .px_valid(px_valid),
        .px_x(px_x), .px_y(px_y), .px_id(px_id)
    );

    always #5 clk = ~clk;

    // Behavioral engine: capture v0..v2, stream them as pixels, then drop busy
    logic [2:0] evx [3];
    logic [2:0] evy [3];
    logic [2:0] eph;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eph <= 3'd0; tri_busy <= 1'b0; tri_po <= 1'b0; tri_xo <= 3'd0; tri_yo <= 3'd0;
            for (int i = 0; i < 3; i++) begin evx[i] <= 3'd0; evy[i] <= 3'd0; end
        end else if (tri_nt) begin
            evx[0] <= tri_xi; evy[0] <= tri_yi; eph <= 3'd1; tri_busy <= 1'b1; tri_po <= 1'b0;
        end else begin
            case (eph)
                3'd1: begin evx[1] <= tri_xi; evy[1] <= tri_yi; eph <= 3'd2; end
                3'd2: begin
                    evx[2] <= tri_xi; evy[2] <= tri_yi; eph <= 3'd3;
                    tri_po <= 1'b1; tri_xo <= evx[0]; tri_yo <= evy[0];
                end
                3'd3: begin tri_xo <= evx[1]; tri_yo <= evy[1]; eph <= 3'd4; end
                3'd4: begin tri_xo <= evx[2]; tri_yo <= evy[2]; eph <= 3'd5; end
                3'd5: begin
                    tri_po <= 1'b0;
                    if (!eng_hang) begin tri_busy <= 1'b0; eph <= 3'd0; end
                end
                default: eph <= 3'd0;
            endcase
        end
    end

    // Event monitor: per-requester ack/done counts and grant-overlap violations
    int ack_cnt [4]  = '{0, 0, 0, 0};
    int done_cnt [4] = '{0, 0, 0, 0};
    int viol = 0;
    bit job_open = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            job_open <= 1'b0;
        end else begin
            if (($countones(ack) > 1) || ((|ack) && job_open)) viol <= viol + 1;
            if (|ack) job_open <= 1'b1;
            if (|done) job_open <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
                if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int oh2id(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 99;
    endfunction

    task automatic wait_ack(input string tag, input int exp_id, input bit drop);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (|ack) seen = 1'b1;
        end
        if (seen) begin
            check(tag, oh2id(ack), exp_id);
            if (drop) req[oh2id(ack)] = 1'b0;
        end else begin
            check(tag, 99, exp_id);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_id, input int exp_err);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 150) begin
            @(negedge clk);
            n++;
            if (|done) seen = 1'b1;
        end
        if (seen) begin
            check(tag, oh2id(done), exp_id);
            check({tag, "_err"}, err, exp_err);
            check({tag, "_id"}, px_id, exp_id);
        end else begin
            check(tag, 99, exp_id);
        end
    endtask

    // Single-job timeline, cycles T+1..T+9 after the grant edge T
    int t1_ack [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    int t1_nt  [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    int t1_xi  [9] = '{1, 4, 1, 0, 0, 0, 0, 0, 0};
    int t1_yi  [9] = '{1, 1, 4, 0, 0, 0, 0, 0, 0};
    int t1_pv  [9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
    int t1_px  [9] = '{0, 0, 0, 0, 1, 4, 1, 0, 0};
    int t1_py  [9] = '{0, 0, 0, 0, 1, 1, 4, 0, 0};
    int t1_dn  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

    int d0_before, a1_before, d1_before;

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        eng_hang = 1'b0;
        req_xv   = {9'o777, 9'o326, 9'o752, 9'o141};
        req_yv   = {9'o000, 9'o154, 9'o603, 9'o411};
        repeat (2) @(negedge clk);
        check("reset_outputs", {ack, done, err, tri_nt, tri_xi, tri_yi,
                                px_valid, px_x, px_y, px_id}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single request with cycle-exact serialization and pixel mirroring
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) req[0] = 1'b0;
            check($sformatf("t1_ack_c%0d", c + 1), ack, t1_ack[c]);
            check($sformatf("t1_nt_c%0d", c + 1), tri_nt, t1_nt[c]);
            check($sformatf("t1_xi_c%0d", c + 1), tri_xi, t1_xi[c]);
            check($sformatf("t1_yi_c%0d", c + 1), tri_yi, t1_yi[c]);
            check($sformatf("t1_pv_c%0d", c + 1), px_valid, t1_pv[c]);
            check($sformatf("t1_px_c%0d", c + 1), px_x, t1_px[c]);
            check($sformatf("t1_py_c%0d", c + 1), px_y, t1_py[c]);
            check($sformatf("t1_done_c%0d", c + 1), done, t1_dn[c]);
            check($sformatf("t1_err_c%0d", c + 1), err, 0);
            check($sformatf("t1_id_c%0d", c + 1), px_id, 0);
        end

        // All four together from reset, then 0 and 2 again
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1111;
        for (int j = 0; j < 4; j++) wait_ack($sformatf("t2_grant%0d", j), j, 1'b1);
        wait_done("t2_done3", 3, 0);
        req = 4'b0101;
        wait_ack("t2_regrant_a", 0, 1'b1);
        wait_ack("t2_regrant_b", 2, 1'b1);
        wait_done("t2_done2", 2, 0);

        // Fairness: req[1] held, req[3] arrives during job 1
        req[1] = 1'b1;
        wait_ack("t3_g1", 1, 1'b0);
        req[3] = 1'b1;
        wait_ack("t3_g2", 3, 1'b1);
        wait_ack("t3_g3", 1, 1'b1);
        wait_done("t3_done", 1, 0);

        // Watchdog: engine never drops busy
        eng_hang = 1'b1;
        req[0] = 1'b1;
        wait_ack("t4_g", 0, 1'b1);
        repeat (82) @(negedge clk);
        check("t4_early_done", done, 0);
        @(negedge clk);
        check("t4_wd_done", done, 4'b0001);
        check("t4_wd_err", err, 1);
        check("t4_wd_id", px_id, 0);
        eng_hang = 1'b0;
        req[3] = 1'b1;
        wait_ack("t4_after_g", 3, 1'b1);
        wait_done("t4_after_done", 3, 0);

        // Reset while pixels stream
        req[0] = 1'b1;
        wait_ack("t5_g", 0, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_streaming", px_valid, 1);
        d0_before = done_cnt[0];
        req[2] = 1'b1;
        req[3] = 1'b1;
        reset = 1'b0;
        #1;
        check("t5_rst_outputs", {ack, done, err, tri_nt, tri_xi, tri_yi,
                                 px_valid, px_x, px_y, px_id}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_ack("t5_first", 2, 1'b1);
        wait_ack("t5_second", 3, 1'b1);
        wait_done("t5_done3", 3, 0);
        check("t5_no_done0", done_cnt[0], d0_before);

        // Withdrawn request during another job
        a1_before = ack_cnt[1];
        d1_before = done_cnt[1];
        req[0] = 1'b1;
        wait_ack("t6_g", 0, 1'b1);
        @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        wait_done("t6_done", 0, 0);
        repeat (12) @(negedge clk);
        check("t6_no_ack1", ack_cnt[1], a1_before);
        check("t6_no_done1", done_cnt[1], d1_before);

        check("ack_cnt0", ack_cnt[0], 6);
        check("ack_cnt1", ack_cnt[1], 3);
        check("ack_cnt2", ack_cnt[2], 3);
        check("ack_cnt3", ack_cnt[3], 4);
        check("done_cnt0", done_cnt[0], 5);
        check("done_cnt1", done_cnt[1], 3);
        check("done_cnt2", done_cnt[2], 3);
        check("done_cnt3", done_cnt[3], 4);
        check("grant_overlap", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tri_sched.md
# tri_sched

Round-robin scheduler that shares one triangle rasterizer engine among up to four requesters. Each requester presents a complete triangle (three 3-bit vertices) with a req/ack handshake. The block grants one request at a time and serializes the vertices onto the engine's nt/xi/yi inputs. It forwards the engine's pixel stream tagged with the owner id, then signals per-requester completion, with a watchdog that aborts hung jobs. It sits between the requester-side logic and the rasterizer core.

## Interface
- N_REQ, 4: number of requesters, legal 2..4.
- ID_W, 2: width of requester id; must satisfy 2^ID_W >= N_REQ.
- TMO, 80: watchdog limit in cycles spent in RUN; legal 8..127.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held high until the matching ack.
- req_xv  in  9*N_REQ  requester i vertices x0,x1,x2 at bits [9i+8:9i], x0 in LSBs.
- req_yv  in  9*N_REQ  same packing for y.
- ack  out  N_REQ  one-cycle pulse; vertices of requester i were latched.
- done  out  N_REQ  one-cycle pulse; job of requester i finished or aborted.
- err  out  1  valid with done; 1 = watchdog abort.
- tri_nt  out  1  engine start strobe, carries vertex 0.
- tri_xi, tri_yi  out  3 each  vertex to engine.
- tri_busy  in  1  engine busy.
- tri_po, tri_xo, tri_yo  in  1/3/3  engine pixel valid and coordinates.
- px_valid  out  1  forwarded pixel valid.
- px_x, px_y  out  3 each  forwarded pixel.
- px_id  out  ID_W  owner of the current job; valid whenever px_valid or done is high.

## Operation
- Engine contract: the engine samples vertex 0 on the cycle tri_nt=1, then vertex 1 and vertex 2 on the next two cycles. tri_busy rises no later than the RUN entry and falls after the last pixel. tri_po is meaningful only while tri_busy=1.
- States: IDLE, SEND0, SEND1, SEND2, RUN, DONE.
- IDLE: if any req bit is high, pick the winner by round robin and go to SEND0. The search starts at rr_ptr and wraps upward modulo N_REQ. On the grant edge:
  - latch the winner's 18 vertex bits and its id;
  - pulse ack[winner] on the next cycle;
  - set rr_ptr = winner+1 mod N_REQ.
- SEND0: drive tri_nt=1 with x0/y0. SEND1 drives x1/y1 and SEND2 drives x2/y2, both with tri_nt=0.
- Outside SEND*, tri_xi=tri_yi=0 and tri_nt=0.
- RUN: register tri_po/xo/yo into px_valid/px_x/px_y, a 1-cycle delay. The watchdog counter clears on RUN entry and increments each RUN cycle.
  - Exit to DONE with err=0 when tri_busy is sampled low at least 2 cycles after RUN entry.
  - Exit to DONE with err=1 when the counter reaches TMO.
- DONE: pulse done[id] and err for one cycle, force px_valid=0, return to IDLE.
- Requests arriving during a job wait. A req that drops before its grant is simply not served. A new grant can only be issued from IDLE, so jobs never overlap.
- Requester bits at index >= N_REQ do not exist. The round-robin pointer never takes such values.

## Timing
- Reset values: state=IDLE, rr_ptr=0, and every output is 0 (ack, done, err, tri_nt, tri_xi, tri_yi, px_*).
- Reset asserted mid-job aborts the job with no done pulse. Every output returns to 0 asynchronously.
- All outputs are registered.
- Latencies:
  - req high in IDLE (sampled at edge T): ack at T+1, tri_nt=1 in cycle T+1, vertex 2 in cycle T+3, RUN from T+4.
  - Pixel: tri_po at edge E appears on px_valid after edge E+1.
- Minimum job, from grant edge to done pulse: 4 + 2 + 1 = 7 cycles. Minimum back-to-back spacing between grants is 8 cycles.
- Simultaneous requests: exactly one ack per grant, chosen by rr_ptr. A requester re-requesting right after done gets no priority over others.
- Watchdog abort: done, err=1 and the id are valid together. The engine is not reset by this block; the next job's tri_nt restarts it.

## Test plan
- Single request: req[0] with vertices (1,1),(4,1),(1,4), behavioral engine attached.
  - Required: ack[0] one cycle after the sample, then the three vertices on consecutive cycles with tri_nt only on the first.
  - Required: every engine pixel mirrored one cycle later with px_id=0, then done[0] with err=0.
- All four requests asserted together from reset.
  - Required: grants in order 0,1,2,3, each ack only after the previous done.
  - Required: re-asserting req[0] and req[2] after that gives order 0 then 2.
- Fairness: req[1] held continuously while req[3] arrives during job 1.
  - Required: the next grant goes to 3, then 1.
- Watchdog: engine model holds tri_busy=1 forever.
  - Required: done[id] and err=1 exactly TMO=80 cycles after RUN entry, then IDLE accepts a new request normally.
- Reset mid-RUN: pull reset low while pixels are streaming.
  - Required: all outputs 0 immediately, no done pulse.
  - Required: after release, a pending req[2] is granted first among 2 and 3 (rr_ptr=0, so 2 wins over 3).
- Withdrawn request: req[1] pulsed for one cycle while another job runs.
  - Required: no ack[1] and no done[1] ever produced.
